// File: rtl/set_scan_datapath.sv
// set_scan_datapath
//   Counts how many points of the 8x8 grid (x,y in 1..8) satisfy a set
//   operation over up to three circles. Four points are tested per cycle.
//   A two-stage pipeline holds a per-cycle count, then an 8-bit accumulator.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   buffer_en_i  load central_i/radius_i/mode_i (ignored while acc_en_i=1)
//   central_i    {x1,y1,x2,y2,x3,y3}, 4-bit unsigned each
//   radius_i     {r1,r2,r3}, 4-bit unsigned each
//   mode_i       0: A, 1: A&B, 2: A^B, 3: exactly two of A,B,C
//   coord_en_i   restart scan (k=0)
//   acc_clear_i  clear accumulator and pipeline stage
//   acc_en_i     scan/accumulate enable
//   clear_i      end-of-job flush (k=16, stage invalid)
//   candidate_o  number of qualifying grid points (0..64)
module set_scan_datapath (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        buffer_en_i,
  input  logic [23:0] central_i,
  input  logic [11:0] radius_i,
  input  logic [1:0]  mode_i,
  input  logic        coord_en_i,
  input  logic        acc_clear_i,
  input  logic        acc_en_i,
  input  logic        clear_i,
  output logic [7:0]  candidate_o
);

  logic [23:0] central_q, central_d;
  logic [11:0] radius_q,  radius_d;
  logic [1:0]  mode_q,    mode_d;
  logic [4:0]  k_q,       k_d;
  logic [2:0]  cnt_q,     cnt_d;
  logic        vld_q,     vld_d;
  logic [7:0]  acc_q,     acc_d;

  logic [2:0]  pts_cnt;
  logic        scan_active;

  // Squared distance compared against r^2; the difference is taken as a
  // 5-bit signed value and squared through its magnitude.
  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] r);
    logic [4:0] dx, dy;
    logic [3:0] ax, ay;
    logic [7:0] sx, sy, rr;
    logic [8:0] sum;
    dx  = {1'b0, px} - {1'b0, cx};
    dy  = {1'b0, py} - {1'b0, cy};
    ax  = dx[4] ? 4'(-dx) : dx[3:0];
    ay  = dy[4] ? 4'(-dy) : dy[3:0];
    sx  = 8'(ax) * 8'(ax);
    sy  = 8'(ay) * 8'(ay);
    rr  = 8'(r) * 8'(r);
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= {1'b0, rr};
  endfunction

  assign scan_active = (k_q < 5'd16);

  always_comb begin
    logic [3:0] px, py;
    logic       a, b, c, q;
    pts_cnt = '0;
    py      = 4'(k_q[3:1]) + 4'd1;
    for (int unsigned j = 0; j < 4; j++) begin
      px = {1'b0, k_q[0], 2'b00} + 4'(j) + 4'd1;
      a  = in_circle(px, py, central_q[23:20], central_q[19:16], radius_q[11:8]);
      b  = in_circle(px, py, central_q[15:12], central_q[11:8],  radius_q[7:4]);
      c  = in_circle(px, py, central_q[7:4],   central_q[3:0],   radius_q[3:0]);
      unique case (mode_q)
        2'd0:    q = a;
        2'd1:    q = a & b;
        2'd2:    q = a ^ b;
        default: q = (2'(a) + 2'(b) + 2'(c)) == 2'd2;
      endcase
      pts_cnt = pts_cnt + 3'(q);
    end
  end

  always_comb begin
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    vld_d     = vld_q;
    acc_d     = acc_q;

    if (buffer_en_i && !acc_en_i) begin
      central_d = central_i;
      radius_d  = radius_i;
      mode_d    = mode_i;
    end

    // Scan index: restart beats flush beats advance; saturates at 16.
    if (coord_en_i)
      k_d = '0;
    else if (clear_i)
      k_d = 5'd16;
    else if (acc_en_i && scan_active)
      k_d = k_q + 5'd1;

    if (acc_clear_i) begin
      cnt_d = '0;
      vld_d = 1'b0;
    end else if (clear_i) begin
      vld_d = 1'b0;
    end else if (acc_en_i) begin
      if (scan_active) begin
        cnt_d = pts_cnt;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end

    if (acc_clear_i)
      acc_d = '0;
    else if (acc_en_i && vld_q)
      acc_d = acc_q + 8'(cnt_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      k_q       <= 5'd16;
      cnt_q     <= '0;
      vld_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      acc_q     <= acc_d;
    end
  end

  assign candidate_o = acc_q;

endmodule

// File: doc/set_scan_datapath.md
SET_SCAN_DATAPATH -- requirements
Module: set_scan_datapath

Interface
REQ-001 SHALL have port clk_i  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port buffer_en_i  input  1  load strobe for central_i/radius_i/mode_i.
REQ-004 SHALL have port central_i  input  24  {x1,y1,x2,y2,x3,y3}, 4-bit unsigned each, MSB first.
REQ-005 SHALL have port radius_i  input  12  {r1,r2,r3}, 4-bit unsigned each, MSB first.
REQ-006 SHALL have port mode_i  input  2  set-operation select.
REQ-007 SHALL have port coord_en_i  input  1  restart grid scan (controller START).
REQ-008 SHALL have port acc_clear_i  input  1  clear accumulator and pipeline (controller START).
REQ-009 SHALL have port acc_en_i  input  1  scan/accumulate enable (controller BUSY, 17 cycles).
REQ-010 SHALL have port clear_i  input  1  end-of-job scan flush (controller DONE).
REQ-011 SHALL have port candidate_o  output  8  unsigned count of grid points satisfying the mode.

Function
REQ-012 SHALL register central/radius/mode into config registers on any edge with buffer_en_i=1 and acc_en_i=0; SHALL ignore buffer_en_i while acc_en_i=1.
REQ-013 SHALL scan the 8x8 grid x,y in 1..8 using a 5-bit scan index k, 0..16, four points per cycle.
REQ-014 SHALL map index k<16 to row y=k[3:1]+1 and columns x=4*k[0]+1+j, j=0..3.
REQ-015 SHALL treat point (x,y) as inside circle n iff (x-xn)^2+(y-yn)^2 <= rn^2, using 5-bit signed differences, 8-bit squares, 9-bit sum, 8-bit rn^2; no truncation.
REQ-016 SHALL qualify each point by mode: 0 = in A; 1 = in A and B; 2 = in exactly one of A,B; 3 = in exactly two of A,B,C.
REQ-017 Stage 1: on edge with acc_en_i=1 and k<16, SHALL register the 3-bit qualifying count (0..4) of the four points, set stage valid, and increment k.
REQ-018 Stage 1: when acc_en_i=1 and k=16, SHALL hold k at 16 and clear stage valid; k SHALL never wrap.
REQ-019 Stage 2: on edge with acc_en_i=1 and stage valid=1, SHALL add the registered count to the 8-bit accumulator.
REQ-020 Latency: 16 scan cycles + 1 drain cycle = 17 acc_en_i cycles; candidate_o SHALL hold the final total from the edge after the 17th acc_en_i cycle.
REQ-021 Max total is 64; accumulator SHALL not overflow and SHALL not saturate-clip.
REQ-022 With acc_en_i=0, k, stage register and accumulator SHALL hold.
REQ-023 coord_en_i=1 SHALL set k=0; acc_clear_i=1 SHALL zero accumulator, stage count and stage valid.
REQ-024 acc_clear_i/coord_en_i SHALL take priority over acc_en_i in the same cycle.
REQ-025 clear_i=1 SHALL set k=16 and clear stage valid; SHALL NOT change candidate_o; candidate_o stays stable through controller DONE until next acc_clear_i.
REQ-026 candidate_o SHALL be driven directly from the accumulator register (no combinational path from inputs).

Reset
REQ-027 rst_i=1 SHALL immediately force candidate_o=0, accumulator=0, k=16, stage count=0, stage valid=0, config registers=0, independent of clk_i.
REQ-028 Reset asserted mid-scan SHALL abort the job; after release the block SHALL accumulate only after a new coord_en_i/acc_clear_i.

Verification
REQ-029 Mode 0, A=(4,4) r=2, START then 17 acc_en cycles -> candidate_o=13.
REQ-030 Mode 0, A=(4,4) r=15 -> candidate_o=64 (no overflow).
REQ-031 Mode 1, A=B=(4,4) r=2 -> 13; mode 2 same circles -> 0; mode 3, A=B=(4,4) r=2, C=(15,15) r=0 -> 13.
REQ-032 Back-to-back jobs: job1 mode 0 (4,4) r=2 -> 13 held through DONE with clear_i=1; job2 mode 0 (1,1) r=0 -> 1.
REQ-033 buffer_en_i pulsed with new config during acc_en_i -> result unchanged (13); acc_clear_i and acc_en_i high together -> accumulator 0.
REQ-034 rst_i asserted at 8th acc_en cycle, between clock edges -> candidate_o=0 immediately; further acc_en without START -> stays 0.
